// File: rtl/alu_issue_unit.sv
// -----------------------------------------------------------------------------
// alu_issue_unit
//
// Valid/ready front-end for an external combinational ALU. The unit registers
// a tagged request in an issue register and drives the ALU operands from that
// register. On the edge that retires the issue entry, it captures the ALU
// result, flags and tag into a small circular response FIFO. It sustains one
// operation per cycle and keeps a sticky overflow flag for the exception logic.
//
// Ports
//   clk, rst            : clock and synchronous active-high reset
//   req_valid/req_ready : request handshake
//   req_A, req_B,       : operands, ALUop and tag of the request
//   req_op, req_tag
//   alu_A, alu_B,       : operand side of the ALU, driven from the issue register
//   alu_ALUop
//   alu_Result,         : ALU outputs, captured when the issue entry retires
//   alu_Overflow,
//   alu_CarryOut,
//   alu_Zero
//   rsp_valid/rsp_ready : response handshake (FIFO head)
//   rsp_Result, rsp_Overflow, rsp_CarryOut, rsp_Zero, rsp_tag : head entry
//   sticky_ovf          : set by any captured overflow
//   sticky_clr          : clears sticky_ovf (a same-cycle set wins)
//   busy                : issue register valid or FIFO non-empty
// -----------------------------------------------------------------------------
module alu_issue_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_A,
  input  logic [DATA_WIDTH-1:0] req_B,
  input  logic [2:0]            req_op,
  input  logic [TAG_WIDTH-1:0]  req_tag,

  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [2:0]            alu_ALUop,
  input  logic [DATA_WIDTH-1:0] alu_Result,
  input  logic                  alu_Overflow,
  input  logic                  alu_CarryOut,
  input  logic                  alu_Zero,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_Result,
  output logic                  rsp_Overflow,
  output logic                  rsp_CarryOut,
  output logic                  rsp_Zero,
  output logic [TAG_WIDTH-1:0]  rsp_tag,

  output logic                  sticky_ovf,
  input  logic                  sticky_clr,
  output logic                  busy
);

  // RSP_DEPTH is a power of two, so pointers wrap naturally at their width.
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic                  ovf;
    logic                  cry;
    logic                  zero;
    logic [TAG_WIDTH-1:0]  tag;
  } rsp_entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                  iss_valid_q, iss_valid_d;
  logic [DATA_WIDTH-1:0] iss_a_q,     iss_a_d;
  logic [DATA_WIDTH-1:0] iss_b_q,     iss_b_d;
  logic [2:0]            iss_op_q,    iss_op_d;
  logic [TAG_WIDTH-1:0]  iss_tag_q,   iss_tag_d;

  logic [PTR_W-1:0]      wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q,    rd_ptr_d;
  logic [CNT_W-1:0]      count_q,     count_d;
  logic                  sticky_q,    sticky_d;

  rsp_entry_t            mem_q [RSP_DEPTH];
  rsp_entry_t            head;
  rsp_entry_t            capture;

  // ---------------------------------------------------------------------------
  // Handshake and control
  // ---------------------------------------------------------------------------
  logic fifo_full;
  logic fifo_empty;
  logic req_fire;
  logic rsp_fire;
  logic iss_adv;

  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign rsp_valid  = ~fifo_empty;
  assign rsp_fire   = rsp_valid & rsp_ready;

  // The issue entry may retire into a full FIFO only when the head leaves in
  // the same cycle; this is what lets the unit stream at one op per cycle.
  assign iss_adv    = iss_valid_q & (~fifo_full | rsp_fire);
  assign req_ready  = ~iss_valid_q | iss_adv;
  assign req_fire   = req_valid & req_ready;

  assign busy       = iss_valid_q | ~fifo_empty;

  // ---------------------------------------------------------------------------
  // Issue register next state
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_a_d     = iss_a_q;
    iss_b_d     = iss_b_q;
    iss_op_d    = iss_op_q;
    iss_tag_d   = iss_tag_q;
    if (req_fire) begin
      iss_valid_d = 1'b1;
      iss_a_d     = req_A;
      iss_b_d     = req_B;
      iss_op_d    = req_op;
      iss_tag_d   = req_tag;
    end else if (iss_adv) begin
      // Operand fields keep their last values so the ALU inputs stay quiet.
      iss_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointer/count next state and sticky flag
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sticky_d = sticky_q;

    if (iss_adv) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rsp_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({iss_adv, rsp_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;   // idle, or push and pop together
    endcase

    // Set has priority over clear so an overflow is never lost.
    if (iss_adv && alu_Overflow) sticky_d = 1'b1;
    else if (sticky_clr)         sticky_d = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Sequential state with synchronous reset
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid_q <= 1'b0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      iss_op_q    <= '0;
      iss_tag_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sticky_q    <= 1'b0;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_a_q     <= iss_a_d;
      iss_b_q     <= iss_b_d;
      iss_op_q    <= iss_op_d;
      iss_tag_q   <= iss_tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sticky_q    <= sticky_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Response storage
  // ---------------------------------------------------------------------------
  assign capture = '{result: alu_Result,
                     ovf:    alu_Overflow,
                     cry:    alu_CarryOut,
                     zero:   alu_Zero,
                     tag:    iss_tag_q};

  // NOTE: the entry storage has no reset; the count gates every read, so stale
  // contents are never observable and the array can map onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (iss_adv && !rst) begin
      mem_q[wr_ptr_q] <= capture;
    end
  end

  assign head = mem_q[rd_ptr_q];

  // Head fields read as zero while empty so nothing stale leaks out.
  assign rsp_Result   = rsp_valid ? head.result : '0;
  assign rsp_Overflow = rsp_valid & head.ovf;
  assign rsp_CarryOut = rsp_valid & head.cry;
  assign rsp_Zero     = rsp_valid & head.zero;
  assign rsp_tag      = rsp_valid ? head.tag : '0;

  // ---------------------------------------------------------------------------
  // ALU drive and status
  // ---------------------------------------------------------------------------
  assign alu_A      = iss_a_q;
  assign alu_B      = iss_b_q;
  assign alu_ALUop  = iss_op_q;
  assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;

  localparam int DW = 32;
  localparam int TW = 4;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [DW-1:0] req_A, req_B;
  logic [2:0]    req_op;
  logic [TW-1:0] req_tag;
  logic [DW-1:0] alu_A, alu_B;
  logic [2:0]    alu_ALUop;
  logic [DW-1:0] alu_Result;
  logic          alu_Overflow, alu_CarryOut, alu_Zero;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_Result;
  logic          rsp_Overflow, rsp_CarryOut, rsp_Zero;
  logic [TW-1:0] rsp_tag;
  logic          sticky_ovf, sticky_clr, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue_unit #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .RSP_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .req_op(req_op), .req_tag(req_tag),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ALUop(alu_ALUop),
    .alu_Result(alu_Result), .alu_Overflow(alu_Overflow),
    .alu_CarryOut(alu_CarryOut), .alu_Zero(alu_Zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_Result(rsp_Result), .rsp_Overflow(rsp_Overflow),
    .rsp_CarryOut(rsp_CarryOut), .rsp_Zero(rsp_Zero), .rsp_tag(rsp_tag),
    .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr), .busy(busy)
  );

  // Behavioural combinational ALU the unit drives; CarryOut on SUB is borrow.
  logic [DW:0] sum;
  always_comb begin
    sum          = '0;
    alu_Result   = '0;
    alu_Overflow = 1'b0;
    alu_CarryOut = 1'b0;
    case (alu_ALUop)
      OP_AND:  alu_Result = alu_A & alu_B;
      OP_OR:   alu_Result = alu_A | alu_B;
      OP_ADD: begin
        sum          = {1'b0, alu_A} + {1'b0, alu_B};
        alu_Result   = sum[DW-1:0];
        alu_CarryOut = sum[DW];
        alu_Overflow = (alu_A[DW-1] == alu_B[DW-1]) && (sum[DW-1] != alu_A[DW-1]);
      end
      OP_SLTU: alu_Result = {{(DW-1){1'b0}}, (alu_A < alu_B)};
      OP_XOR:  alu_Result = alu_A ^ alu_B;
      OP_NOR:  alu_Result = ~(alu_A | alu_B);
      OP_SUB: begin
        alu_Result   = alu_A - alu_B;
        alu_CarryOut = (alu_A < alu_B);
        alu_Overflow = (alu_A[DW-1] != alu_B[DW-1]) && (alu_Result[DW-1] != alu_A[DW-1]);
      end
      default: alu_Result = {{(DW-1){1'b0}}, ($signed(alu_A) < $signed(alu_B))};
    endcase
  end
  assign alu_Zero = (alu_Result == '0);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    logic          ovf;
    logic          cry;
    logic          zero;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int next_tag;
    int exp_tag;
    int stale;
    bit fire;
    bit first;
    logic [DW-1:0] sa [4];
    logic [DW-1:0] sb [4];
    logic [DW-1:0] sres [4];
    logic          scry [4];
    logic          szero [4];

    vecs[0] = '{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{OP_OR,   32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{OP_XOR,  32'hAAAA_5555, 32'hAAAA_5555, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{OP_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0};

    sa[0] = 5; sb[0] = 5; sres[0] = 32'h0;         scry[0] = 1'b0; szero[0] = 1'b1;
    sa[1] = 0; sb[1] = 1; sres[1] = 32'hFFFF_FFFF; scry[1] = 1'b1; szero[1] = 1'b0;
    sa[2] = 7; sb[2] = 2; sres[2] = 32'h5;         scry[2] = 1'b0; szero[2] = 1'b0;
    sa[3] = 1; sb[3] = 0; sres[3] = 32'h1;         scry[3] = 1'b0; szero[3] = 1'b0;

    rst = 1'b1; req_valid = 1'b0; req_A = '0; req_B = '0; req_op = '0; req_tag = '0;
    rsp_ready = 1'b0; sticky_clr = 1'b0;

    // ---------------- Reset state ----------------
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_A", alu_A, 0);
    check("rst_alu_B", alu_B, 0);
    check("rst_alu_op", alu_ALUop, 0);
    check("rst_rsp_result", rsp_Result, 0);
    check("rst_sticky", sticky_ovf, 0);
    tick();

    // ---------------- Table-driven single ops ----------------
    rsp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      req_valid = 1'b1; req_op = vecs[i].op; req_A = vecs[i].a; req_B = vecs[i].b;
      req_tag = TW'(i);
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_early", i), rsp_valid, 0);
      tick();
      @(negedge clk);
      check($sformatf("v%0d_valid", i), rsp_valid, 1);
      check($sformatf("v%0d_result", i), rsp_Result, vecs[i].res);
      check($sformatf("v%0d_ovf", i), rsp_Overflow, vecs[i].ovf);
      check($sformatf("v%0d_carry", i), rsp_CarryOut, vecs[i].cry);
      check($sformatf("v%0d_zero", i), rsp_Zero, vecs[i].zero);
      check($sformatf("v%0d_tag", i), rsp_tag, i);
      if (i == 2) check("v2_sticky_set", sticky_ovf, 1);
      tick();
    end
    @(negedge clk);
    check("table_drained", busy, 0);
    check("sticky_held_after_pops", sticky_ovf, 1);
    tick();

    // ---------------- Back-to-back SUB stream ----------------
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req_valid = (c < 4);
      req_op = OP_SUB;
      req_A = (c < 4) ? sa[c] : '0;
      req_B = (c < 4) ? sb[c] : '0;
      req_tag = TW'(c);
      @(negedge clk);
      if (c < 4) check($sformatf("stream_ready_c%0d", c), req_ready, 1);
      if (c == 1) check("stream_latency", rsp_valid, 0);
      if (c >= 2 && c <= 5) begin
        check($sformatf("stream_valid_%0d", c - 2), rsp_valid, 1);
        check($sformatf("stream_result_%0d", c - 2), rsp_Result, sres[c-2]);
        check($sformatf("stream_carry_%0d", c - 2), rsp_CarryOut, scry[c-2]);
        check($sformatf("stream_zero_%0d", c - 2), rsp_Zero, szero[c-2]);
        check($sformatf("stream_ovf_%0d", c - 2), rsp_Overflow, 0);
        check($sformatf("stream_tag_%0d", c - 2), rsp_tag, c - 2);
      end
      if (c == 6) check("stream_drained", rsp_valid, 0);
      tick();
    end
    check("stream_sticky_clear", sticky_ovf, 0);

    // ---------------- Backpressure: fill to capacity ----------------
    rsp_ready = 1'b0;
    next_tag = 0;
    for (int c = 0; c < 6; c++) begin
      req_valid = (next_tag < 5);
      req_op = OP_ADD; req_A = DW'(next_tag * 10); req_B = DW'(next_tag);
      req_tag = TW'(next_tag);
      @(negedge clk);
      fire = req_valid && req_ready;
      tick();
      if (fire) next_tag++;
    end
    @(negedge clk);
    check("bp_accepted", next_tag, 3);
    check("bp_req_ready_low", req_ready, 0);
    check("bp_head_tag", rsp_tag, 0);
    check("bp_busy", busy, 1);
    tick();

    // ---------------- Drain: first cycle is push+pop while full ----------------
    exp_tag = 0;
    first = 1'b1;
    for (int c = 0; c < 30 && exp_tag < 5; c++) begin
      rsp_ready = 1'b1;
      req_valid = (next_tag < 5);
      req_op = OP_ADD; req_A = DW'(next_tag * 10); req_B = DW'(next_tag);
      req_tag = TW'(next_tag);
      @(negedge clk);
      if (first) check("bp_push_pop_ready", req_ready, 1);
      first = 1'b0;
      fire = req_valid && req_ready;
      if (rsp_valid) begin
        check($sformatf("bp_tag_%0d", exp_tag), rsp_tag, exp_tag);
        check($sformatf("bp_result_%0d", exp_tag), rsp_Result, exp_tag * 11);
        exp_tag++;
      end
      tick();
      if (fire) next_tag++;
    end
    req_valid = 1'b0;
    check("bp_all_accepted", next_tag, 5);
    check("bp_all_returned", exp_tag, 5);
    @(negedge clk);
    check("bp_no_duplicate", rsp_valid, 0);
    check("bp_idle", busy, 0);
    tick();

    // ---------------- Sticky set wins over clear ----------------
    req_valid = 1'b1; req_op = OP_ADD; req_A = 32'h7FFF_FFFF; req_B = 32'h1; req_tag = 4'd5;
    tick();
    req_valid = 1'b0;
    sticky_clr = 1'b1;
    tick();
    @(negedge clk);
    check("sticky_set_wins", sticky_ovf, 1);
    tick();
    @(negedge clk);
    check("sticky_cleared", sticky_ovf, 0);
    sticky_clr = 1'b0;
    tick();

    // ---------------- Reset mid-flight ----------------
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_op = OP_ADD;
      req_A = (k == 0) ? 32'h7FFF_FFFF : DW'(k); req_B = 32'h1; req_tag = TW'(7 + k);
      tick();
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_sticky", sticky_ovf, 1);
    check("mid_full", req_ready, 0);
    tick();
    rst = 1'b1;
    req_valid = 1'b1; req_op = OP_OR; req_A = 32'h55; req_B = 32'h55; req_tag = 4'hF;
    tick();
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("mrst_rsp_valid", rsp_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_req_ready", req_ready, 1);
    check("mrst_sticky", sticky_ovf, 0);
    check("mrst_alu_A", alu_A, 0);
    tick();
    rsp_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) stale++;
      tick();
    end
    check("mrst_no_stale", stale, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
